// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and constants for the multi-cycle multiply sequencer.
// Optional feature macro: MUL_SEQ_HI_EN (issue the high partial, full 2*WIDTH product).
package mul_seq_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   // Partial-product index: bit1 selects the A high half, bit0 the B high half.
   typedef logic [1:0] pidx_t;

`ifdef MUL_SEQ_HI_EN
   localparam int MUL_SEQ_NPART = 4;
`else
   localparam int MUL_SEQ_NPART = 3;
`endif

   // Accept edge to first rsp_valid cycle.
   localparam int    MUL_SEQ_LATENCY = MUL_SEQ_NPART + 2;
   localparam pidx_t MUL_SEQ_LAST_K  = pidx_t'(MUL_SEQ_NPART - 1);

   // Accumulate shift of each partial, in half-word units.
   localparam int P0_SHIFT = 0;
   localparam int P1_SHIFT = 1;
   localparam int P2_SHIFT = 1;
   localparam int P3_SHIFT = 2;

   function automatic int pp_shift_units(input pidx_t k);
      case (k)
         2'd0:    return P0_SHIFT;
         2'd1:    return P1_SHIFT;
         2'd2:    return P2_SHIFT;
         default: return P3_SHIFT;
      endcase
   endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: request/response handshake bundle of the multiply sequencer.
interface mul_seq_ctrl_if #(parameter int WIDTH = 32);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             kill;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_lo;
   logic [WIDTH-1:0] rsp_hi;
   logic             busy;

   modport master (
      output req_valid, req_a, req_b, kill, rsp_ready,
      input  req_ready, rsp_valid, rsp_lo, rsp_hi, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, kill, rsp_ready,
      output req_ready, rsp_valid, rsp_lo, rsp_hi, busy
   );
endinterface

// File: rtl/mul16_cell.sv
// mul16_cell: registered HW x HW unsigned multiplier, one-cycle latency,
// clock enable and asynchronous active-high clear (maps onto a DSP block).
module mul16_cell #(
   parameter int HW = 16
) (
   input  logic            clk,
   input  logic            i_aclr,
   input  logic            i_ena,
   input  logic [HW-1:0]   i_a,
   input  logic [HW-1:0]   i_b,
   output logic [2*HW-1:0] o_p
);

   logic [2*HW-1:0] r_p;

   // Product register; holds its value whenever the enable is low.
   always_ff @(posedge clk or posedge i_aclr) begin
      if (i_aclr)     r_p <= '0;
      else if (i_ena) r_p <= (2*HW)'(i_a) * (2*HW)'(i_b);
   end

   assign o_p = r_p;

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 32x32 multiply sequenced over one registered half-width cell.
// Partials are issued one per cycle and accumulated one cycle later.
// Macro MUL_SEQ_HI_EN: adds the ahi*bhi partial and returns the high word;
// without it the accumulator is WIDTH bits and rsp_hi is tied to zero.
module mul_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           reset,
   mul_seq_ctrl_if.slave bus
);

   localparam int HW = WIDTH / 2;
`ifdef MUL_SEQ_HI_EN
   localparam int ACC_W = 2 * WIDTH;
`else
   localparam int ACC_W = WIDTH;
`endif

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, r_b;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_pp_ext, w_pp_sh, w_acc_sum;
   pidx_t            r_k, r_pend_k;
   logic             r_pend;
   logic [WIDTH-1:0] r_rsp_lo;
   logic             w_req_ready, w_busy, w_rsp_valid, w_cell_ena;
   logic             w_accept;
   logic [HW-1:0]    w_cell_a, w_cell_b;
   logic [WIDTH-1:0] w_cell_p;

   assign w_accept = bus.req_valid & w_req_ready;

   // Half-word selection for the partial currently being issued.
   assign w_cell_a = r_k[1] ? r_a[WIDTH-1:HW] : r_a[HW-1:0];
   assign w_cell_b = r_k[0] ? r_b[WIDTH-1:HW] : r_b[HW-1:0];

   mul16_cell #(.HW(HW)) u_cell (
      .clk    (clk),
      .i_aclr (reset),
      .i_ena  (w_cell_ena),
      .i_a    (w_cell_a),
      .i_b    (w_cell_b),
      .o_p    (w_cell_p)
   );

   // Align the cell output of the pending partial and add it to the accumulator.
   always_comb begin
      w_pp_ext  = ACC_W'(w_cell_p);
      w_pp_sh   = w_pp_ext << (HW * pp_shift_units(r_pend_k));
      w_acc_sum = r_acc + w_pp_sh;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; kill returns to IDLE from any busy state.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:  if (w_accept) w_state_nxt = ISSUE;
         ISSUE: begin
            if (bus.kill)                  w_state_nxt = IDLE;
            else if (r_k == MUL_SEQ_LAST_K) w_state_nxt = DRAIN;
         end
         DRAIN: w_state_nxt = bus.kill ? IDLE : DONE;
         DONE:  if (bus.kill || bus.rsp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs; the cell runs in ISSUE and the cycle after.
   always_comb begin
      w_req_ready = 1'b0;
      w_busy      = 1'b0;
      w_rsp_valid = 1'b0;
      w_cell_ena  = 1'b0;
      case (r_state)
         IDLE:  w_req_ready = ~bus.kill & ~reset;
         ISSUE: begin
            w_busy     = 1'b1;
            w_cell_ena = ~bus.kill;
         end
         DRAIN: begin
            w_busy     = 1'b1;
            w_cell_ena = ~bus.kill;
         end
         DONE: begin
            w_busy      = 1'b1;
            w_rsp_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Operand capture, partial sequencing, accumulation and result load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_k      <= '0;
         r_pend   <= 1'b0;
         r_pend_k <= '0;
         r_rsp_lo <= '0;
      end else if (w_accept) begin
         r_a      <= bus.req_a;
         r_b      <= bus.req_b;
         r_acc    <= '0;
         r_k      <= '0;
         r_pend   <= 1'b0;
         r_rsp_lo <= '0;
      end else begin
         r_pend   <= (r_state == ISSUE) & ~bus.kill;
         r_pend_k <= r_k;
         if (r_state == ISSUE) r_k <= r_k + 2'd1;
         if (r_pend)           r_acc <= w_acc_sum;
         if ((r_state == DRAIN) && !bus.kill) r_rsp_lo <= w_acc_sum[WIDTH-1:0];
      end
   end

`ifdef MUL_SEQ_HI_EN
   logic [WIDTH-1:0] r_rsp_hi;

   // High result word, loaded together with the low word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                r_rsp_hi <= '0;
      else if (w_accept)                        r_rsp_hi <= '0;
      else if ((r_state == DRAIN) && !bus.kill) r_rsp_hi <= w_acc_sum[ACC_W-1:WIDTH];
   end

   assign bus.rsp_hi = r_rsp_hi;
`else
   assign bus.rsp_hi = '0;
`endif

   assign bus.req_ready = w_req_ready;
   assign bus.busy      = w_busy;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_lo    = r_rsp_lo;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed checks of the multiply sequencer plus a random
// back-to-back run against a 64-bit reference product.
module tb_mul_seq_ctrl;

   localparam int W = 32;
`ifdef MUL_SEQ_HI_EN
   localparam bit HI  = 1'b1;
   localparam int LAT = 6;
`else
   localparam bit HI  = 1'b0;
   localparam int LAT = 5;
`endif

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   mul_seq_ctrl_if #(.WIDTH(W)) bus ();

   mul_seq_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_hi(input logic [63:0] p);
      return HI ? p[63:32] : 32'h0;
   endfunction

   // Present a request and wait for acceptance; returns in cycle T0+1.
   task automatic send(input logic [31:0] a, input logic [31:0] b, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
      #1;
      for (int i = 0; i < 50; i++) begin
         if (bus.req_ready) begin ok = 1'b1; break; end
         @(negedge clk); #1;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   // Called in cycle T0+1; returns in the first rsp_valid cycle with its index.
   task automatic wait_rsp(output int lat, output bit ok);
      lat = 1; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.rsp_valid) begin ok = 1'b1; break; end
         @(negedge clk); lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0;
      bus.kill = 1'b0; bus.rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.rsp_lo !== 32'h0 || bus.rsp_hi !== 32'h0) begin
         bad++;
         $display("FAIL reset_state: rdy=%b vld=%b busy=%b lo=%h hi=%h want 0 0 0 0 0",
                  bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_lo, bus.rsp_hi);
      end
      reset = 1'b0;
      #1;
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_basic();
      logic [31:0] va [2];
      logic [31:0] vb [2];
      logic [31:0] elo [2];
      logic [31:0] ehi [2];
      int lat; bit ok, ok2;
      va[0] = 32'h0001_0002; vb[0] = 32'h0003_0004; elo[0] = 32'h000A_0008; ehi[0] = HI ? 32'h3 : 32'h0;
      va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; elo[1] = 32'h0000_0001; ehi[1] = HI ? 32'hFFFF_FFFE : 32'h0;
      bus.rsp_ready = 1'b1;
      for (int n = 0; n < 2; n++) begin
         send(va[n], vb[n], ok);
         wait_rsp(lat, ok2);
         total++;
         if (!ok || !ok2 || lat != LAT) begin
            bad++; $display("FAIL basic%0d_latency: acc=%b rsp=%b lat=%0d want %0d", n, ok, ok2, lat, LAT);
         end
         total++;
         if (bus.rsp_lo !== elo[n] || bus.rsp_hi !== ehi[n]) begin
            bad++; $display("FAIL basic%0d_result: lo=%h hi=%h want lo=%h hi=%h",
                            n, bus.rsp_lo, bus.rsp_hi, elo[n], ehi[n]);
         end
         @(negedge clk); #1;
         total++;
         if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL basic%0d_done_one_cycle: vld=%b busy=%b rdy=%b want 0 0 1",
                            n, bus.rsp_valid, bus.busy, bus.req_ready);
         end
      end
   endtask

   task automatic test_stall();
      int lat; bit ok, ok2, st;
      bus.rsp_ready = 1'b0;
      send(32'h1234_5678, 32'h0000_0010, ok);
      wait_rsp(lat, ok2);
      total++;
      if (!ok || !ok2 || bus.rsp_lo !== 32'h2345_6780 || bus.rsp_hi !== (HI ? 32'h1 : 32'h0)) begin
         bad++; $display("FAIL stall_result: ok=%b%b lo=%h hi=%h want lo=23456780 hi=%0d",
                         ok, ok2, bus.rsp_lo, bus.rsp_hi, HI);
      end
      bus.req_a = 32'd6; bus.req_b = 32'd7; bus.req_valid = 1'b1;
      st = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_lo !== 32'h2345_6780 || bus.req_ready !== 1'b0) st = 1'b0;
      end
      total++;
      if (!st) begin
         bad++; $display("FAIL stall_hold: vld=%b lo=%h rdy=%b want 1 23456780 0",
                         bus.rsp_valid, bus.rsp_lo, bus.req_ready);
      end
      bus.rsp_ready = 1'b1;
      #1;
      total++;
      if (bus.req_ready !== 1'b0) begin
         bad++; $display("FAIL stall_ready_at_handshake: got %b want 0", bus.req_ready);
      end
      @(negedge clk); #1;
      total++;
      if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL stall_ready_after: busy=%b rdy=%b want 0 1", bus.busy, bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b1) begin
         bad++; $display("FAIL stall_pending_accept: busy=%b want 1", bus.busy);
      end
      wait_rsp(lat, ok2);
      total++;
      if (!ok2 || lat != LAT || bus.rsp_lo !== 32'd42 || bus.rsp_hi !== 32'd0) begin
         bad++; $display("FAIL stall_second: lat=%0d lo=%0d hi=%0d want lat=%0d lo=42 hi=0",
                         lat, bus.rsp_lo, bus.rsp_hi, LAT);
      end
      @(negedge clk);
   endtask

   task automatic test_kill();
      int lat; bit ok, ok2, seen;
      bus.rsp_ready = 1'b1;
      bus.kill = 1'b1; bus.req_valid = 1'b1; bus.req_a = 32'd3; bus.req_b = 32'd3;
      #1;
      total++;
      if (bus.req_ready !== 1'b0) begin
         bad++; $display("FAIL kill_idle_block: rdy=%b want 0", bus.req_ready);
      end
      @(negedge clk); #1;
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL kill_idle_no_accept: busy=%b want 0", bus.busy);
      end
      bus.kill = 1'b0; bus.req_valid = 1'b0;
      send(32'd100, 32'd200, ok);
      @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      #1;
      total++;
      if (!ok || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL kill_abort: acc=%b rdy=%b busy=%b want 1 1 0", ok, bus.req_ready, bus.busy);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++; $display("FAIL kill_no_rsp: rsp_valid seen=1 want 0");
      end
      send(32'd7, 32'd9, ok);
      wait_rsp(lat, ok2);
      total++;
      if (!ok || !ok2 || lat != LAT || bus.rsp_lo !== 32'd63 || bus.rsp_hi !== 32'd0) begin
         bad++; $display("FAIL kill_followup: lat=%0d lo=%0d hi=%0d want lat=%0d lo=63 hi=0",
                         lat, bus.rsp_lo, bus.rsp_hi, LAT);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat; bit ok, ok2;
      bus.rsp_ready = 1'b1;
      send(32'h0000_FFFF, 32'h0000_FFFF, ok);
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0 ||
          bus.rsp_lo !== 32'h0 || bus.rsp_hi !== 32'h0) begin
         bad++; $display("FAIL reset_mid: busy=%b vld=%b rdy=%b lo=%h hi=%h want all 0",
                         bus.busy, bus.rsp_valid, bus.req_ready, bus.rsp_lo, bus.rsp_hi);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send(32'h0001_0000, 32'h0001_0000, ok);
      wait_rsp(lat, ok2);
      total++;
      if (!ok || !ok2 || lat != LAT || bus.rsp_lo !== 32'h0 || bus.rsp_hi !== (HI ? 32'h1 : 32'h0)) begin
         bad++; $display("FAIL reset_mid_followup: lat=%0d lo=%h hi=%h want lat=%0d lo=0 hi=%0d",
                         lat, bus.rsp_lo, bus.rsp_hi, LAT, HI);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      logic [63:0] p;
      bit ok, got;
      int stall;
      bus.rsp_ready = 1'b0;
      for (int n = 0; n < 200; n++) begin
         a = $urandom; b = $urandom;
         if (n == 0) a = 32'h0;
         if (n == 1) b = 32'hFFFF_FFFF;
         p = 64'(a) * 64'(b);
         bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
         #1;
         ok = 1'b0;
         for (int i = 0; i < 50; i++) begin
            if (bus.req_ready) begin ok = 1'b1; break; end
            @(negedge clk); #1;
         end
         @(negedge clk);
         bus.req_valid = 1'b0;
         got = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
         end
         stall = $urandom_range(0, 3);
         for (int i = 0; i < stall; i++) @(negedge clk);
         bus.rsp_ready = 1'b1;
         total++;
         if (!ok || !got || bus.rsp_valid !== 1'b1 ||
             bus.rsp_lo !== p[31:0] || bus.rsp_hi !== exp_hi(p)) begin
            bad++; $display("FAIL b2b_%0d: a=%h b=%h vld=%b lo=%h hi=%h want lo=%h hi=%h",
                            n, a, b, bus.rsp_valid, bus.rsp_lo, bus.rsp_hi, p[31:0], exp_hi(p));
         end
         @(negedge clk);
         bus.rsp_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_kill();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle multiply sequencer for the Nios-side datapath. It accepts one 32x32 unsigned multiply request at a time over a valid/ready handshake and time-multiplexes a single registered 16x16 multiplier cell across the partial products. It accumulates the shifted partial products and returns the result over a valid/ready response channel. It sits between the CPU execute stage (or any other requester) and the hard-multiplier resource, in place of three parallel multiplier cells.

## Interface
- WIDTH, 32, operand width; must be even; the cell is WIDTH/2 x WIDTH/2 unsigned.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- req_valid  in  1  request present.
- req_ready  out  1  = (state==IDLE) & ~kill; reset 0 while reset is held, 1 after release.
- req_a  in  WIDTH  operand A, sampled on accept.
- req_b  in  WIDTH  operand B, sampled on accept.
- kill  in  1  synchronous abort; discards any in-flight operation with no response.
- rsp_valid  out  1  result valid; reset 0.
- rsp_ready  in  1  consumer accepts result.
- rsp_lo  out  WIDTH  low word of product; reset 0.
- rsp_hi  out  WIDTH  high word of product; reset 0; constant 0 when the high word is compiled out.
- busy  out  1  state != IDLE; reset 0.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - An accept (req_valid & req_ready) latches the operands and clears the 2*WIDTH accumulator, partial-product index k=0 and the response registers.
  - Next state is ISSUE.
- ISSUE:
  - Drives the cell with the half-words for partial k and pulses the cell enable. k increments each cycle.
  - Partial order, with shift applied at accumulate: P0=alo*blo<<0, P1=alo*bhi<<W/2, P2=ahi*blo<<W/2, P3=ahi*bhi<<W.
  - The cell result for partial k arrives one cycle after its issue and is added to the accumulator in that cycle.
  - After the last partial (N-1) is issued, go to DRAIN.
- DRAIN: accumulate the last partial; rsp_lo/rsp_hi load from the accumulator at this edge; next state is DONE.
- DONE:
  - rsp_valid=1, and rsp_lo/rsp_hi are held stable until rsp_ready.
  - rsp_valid & rsp_ready returns to IDLE.
- N=3 without the config macro (low word only, accumulator mod 2^WIDTH); N=4 with it.
- Accumulator arithmetic:
  - All arithmetic is unsigned and zero-extended.
  - Carries out of bit 2*WIDTH-1 are discarded.
  - Intermediate sums never overflow 2*WIDTH bits.
- kill:
  - In ISSUE, DRAIN or DONE, the next state is IDLE and rsp_valid drops the next cycle.
  - The cell enable is forced 0 and accumulator contents are don't-care.
  - kill in IDLE blocks acceptance that cycle.
  - kill and rsp_ready asserted together in DONE: return to IDLE, and the response counts as consumed.
- Asynchronous reset at any point: state IDLE, rsp_valid=0, rsp_lo/rsp_hi=0, cell registers cleared via its aclr.

## Timing
- Acceptance edge = T0.
- ISSUE occupies cycles T0+1 .. T0+N.
- DRAIN is cycle T0+N+1.
- rsp_valid is first high in cycle T0+N+2: latency 5 cycles (N=3) or 6 cycles (N=4).
- req_ready is low from T0+1 until the cycle after the response handshake.
- Best-case throughput is one multiply per N+3 cycles.
- rsp_ready held high: the DONE state lasts exactly one cycle.
- The cell enable is high only in ISSUE cycles and the cycle after, so the cell output is held otherwise.

## Configuration
- MUL_SEQ_HI_EN defined:
  - Issues P3; N=4.
  - rsp_hi carries the full upper product word.
- MUL_SEQ_HI_EN undefined:
  - P3 is skipped; N=3.
  - The accumulator is WIDTH bits and rsp_hi is tied to 0.
  - Required behaviour is identical to Nios mul low-word semantics.

## Structure
- Shared package mul_seq_pkg holds:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - partial-index typedef;
  - per-partial shift constants;
  - MUL_SEQ_LATENCY derived from N.
- One sub-module, mul16_cell: registered WIDTH/2 x WIDTH/2 unsigned multiplier with ena and async-high aclr, one-cycle latency, mapped to dedicated DSP.

## Test plan
- Reset, then a = 0x0001_0002, b = 0x0003_0004 -> rsp_lo = 0x000A_0008; rsp_hi = 0x0000_0003 (HI_EN) or 0; rsp_valid at T0+5 / T0+6.
- a = b = 0xFFFF_FFFF -> rsp_lo = 0x0000_0001; rsp_hi = 0xFFFF_FFFE with HI_EN.
- rsp_ready held low 10 cycles after valid -> rsp stable, req_ready stays 0; a new req_valid during that time is not accepted until one cycle after the handshake.
- kill pulsed at T0+2 -> no rsp_valid ever for that request; req_ready=1 at T0+3; a following request 7 x 9 returns rsp_lo = 63.
- reset asserted mid-ISSUE -> outputs 0 immediately, busy=0; after release, 0x10000 x 0x10000 -> lo 0, hi 1 (HI_EN).
- 200 back-to-back random operand pairs with random rsp_ready stalls -> every result equals the 64-bit reference product (or its low word), in order, and none is dropped.
